// File: rtl/fp_mc_scoreboard.sv
// FP hazard scoreboard for one outstanding FDIV.S/FSQRT.S plus FLW load-use detection.
// Latency: done pulse LAT cycles after issue; stall/bubble are combinational in the same cycle.
// Backpressure: holds IF/ID and injects an ID/EX bubble while ID conflicts with the pending result.
module fp_mc_scoreboard #(
  parameter int DIV_LAT  = 16,
  parameter int SQRT_LAT = 20,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_id,
  input  logic [6:0] funct7_id,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rd_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic       fp_wr_id,
  input  logic       valid_ex,
  input  logic [6:0] opcode_ex,
  input  logic [6:0] funct7_ex,
  input  logic [4:0] rd_ex,
  input  logic       RegWr_ex,
  input  logic       MemRd_ex,
  input  logic       flush_ex,
  output logic       stall_o,
  output logic       bubble_o,
  output logic       mc_busy,
  output logic       mc_done,
  output logic [4:0] mc_rd
);

  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] F7_FDIV  = 7'b0001100;
  localparam logic [6:0] F7_FSQRT = 7'b0101100;

  localparam logic [CNT_W-1:0] DIV_INIT  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] SQRT_INIT = CNT_W'(SQRT_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam int MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;

  if (DIV_LAT < 2 || SQRT_LAT < 2) begin : g_bad_lat
    $error("fp_mc_scoreboard: latencies must be at least 2");
  end
  if ((MAX_LAT - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("fp_mc_scoreboard: CNT_W too narrow for the longest latency");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [4:0]       r_pend_rd;
  logic [4:0]       w_pend_rd_nxt;

  logic       w_busy;
  logic       w_mc_op_ex;
  logic       w_sqrt_ex;
  logic       w_mc_op_id;
  logic       w_flw_ex;
  logic       w_issue;
  logic       w_pend;
  logic [4:0] w_prd;
  logic       w_raw;
  logic       w_waw;
  logic       w_struct;
  logic       w_port;
  logic       w_loaduse;

  assign w_busy     = (r_state == S_BUSY);
  assign w_mc_op_ex = (opcode_ex == OP_FP) && ((funct7_ex == F7_FDIV) || (funct7_ex == F7_FSQRT));
  assign w_sqrt_ex  = (funct7_ex == F7_FSQRT);
  assign w_mc_op_id = (opcode_id == OP_FP) && ((funct7_id == F7_FDIV) || (funct7_id == F7_FSQRT));
  assign w_flw_ex   = (opcode_ex == OP_FLW);
  // A flush never cancels a busy op, it only blocks a new one from entering.
  assign w_issue    = valid_ex & w_mc_op_ex & ~flush_ex & ~w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend_rd <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend_rd <= w_pend_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pend_rd_nxt = r_pend_rd;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt   = S_BUSY;
          w_cnt_nxt     = w_sqrt_ex ? SQRT_INIT : DIV_INIT;
          w_pend_rd_nxt = rd_ex;
        end
      end
      S_BUSY: begin
        // cnt sits at zero for the done cycle, then the op retires.
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mc_busy = w_busy;
    mc_done = w_busy && (r_cnt == '0);
    mc_rd   = w_busy ? r_pend_rd : 5'd0;

    // Same-cycle view: an op issuing right now already blocks ID.
    w_pend = w_busy | w_issue;
    w_prd  = w_busy ? r_pend_rd : rd_ex;

    w_raw     = w_pend & ((use_rs1_id & (rs1_id == w_prd)) | (use_rs2_id & (rs2_id == w_prd)));
    w_waw     = w_pend & fp_wr_id & (rd_id == w_prd);
    w_struct  = w_pend & w_mc_op_id;
    w_port    = mc_done;
    w_loaduse = valid_ex & w_flw_ex & MemRd_ex & RegWr_ex &
                ((use_rs1_id & (rs1_id == rd_ex)) | (use_rs2_id & (rs2_id == rd_ex)));

    stall_o  = (w_raw | w_waw | w_struct | w_port | w_loaduse) & ~flush_ex & rst_n;
    bubble_o = stall_o;
  end

endmodule

// File: tb/tb_fp_mc_scoreboard.sv
// Bench for fp_mc_scoreboard: directed scenarios with literal expectations, then random traffic
// checked every cycle against a timestamp-based model of the outstanding op.
module tb_fp_mc_scoreboard;

  localparam int DIV_LAT  = 16;
  localparam int SQRT_LAT = 20;

  localparam logic [6:0] OP_FP    = 7'b1010011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] OP_INT   = 7'b0110011;
  localparam logic [6:0] F7_FDIV  = 7'b0001100;
  localparam logic [6:0] F7_FSQRT = 7'b0101100;
  localparam logic [6:0] F7_FADD  = 7'b0000000;
  localparam logic [6:0] F7_FMUL  = 7'b0001000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode_id, funct7_id, opcode_ex, funct7_ex;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_ex;
  logic       use_rs1_id, use_rs2_id, fp_wr_id;
  logic       valid_ex, RegWr_ex, MemRd_ex, flush_ex;
  logic       stall_o, bubble_o, mc_busy, mc_done;
  logic [4:0] mc_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_mc_scoreboard #(.DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .opcode_id(opcode_id), .funct7_id(funct7_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rd_id(rd_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .fp_wr_id(fp_wr_id),
    .valid_ex(valid_ex), .opcode_ex(opcode_ex), .funct7_ex(funct7_ex), .rd_ex(rd_ex),
    .RegWr_ex(RegWr_ex), .MemRd_ex(MemRd_ex), .flush_ex(flush_ex),
    .stall_o(stall_o), .bubble_o(bubble_o), .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_done_cyc = 0;
  logic [4:0] m_rd = 5'd0;

  function automatic bit is_mc(input logic [6:0] op, input logic [6:0] f7);
    return (op == OP_FP) && (f7 == F7_FDIV || f7 == F7_FSQRT);
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return (use_rs1_id && rs1_id == r) || (use_rs2_id && rs2_id == r);
  endfunction

  always @(negedge clk) begin : cmp
    bit         e_done, e_issue, e_pend, e_haz, e_stall;
    logic [4:0] e_rd, e_prd;
    cyc++;
    if (!rst_n) m_busy = 1'b0;
    e_done  = m_busy && (cyc == m_done_cyc);
    e_rd    = m_busy ? m_rd : 5'd0;
    e_issue = rst_n && valid_ex && is_mc(opcode_ex, funct7_ex) && !flush_ex && !m_busy;
    e_pend  = m_busy || e_issue;
    e_prd   = m_busy ? m_rd : rd_ex;
    e_haz   = (e_pend && reads(e_prd))
           || (e_pend && fp_wr_id && rd_id == e_prd)
           || (e_pend && is_mc(opcode_id, funct7_id))
           || e_done
           || (valid_ex && opcode_ex == OP_FLW && MemRd_ex && RegWr_ex && reads(rd_ex));
    e_stall = e_haz && !flush_ex && rst_n;
    chk("m_busy",   32'(mc_busy),  32'(m_busy));
    chk("m_done",   32'(mc_done),  32'(e_done));
    chk("m_rd",     32'(mc_rd),    32'(e_rd));
    chk("m_stall",  32'(stall_o),  32'(e_stall));
    chk("m_bubble", 32'(bubble_o), 32'(e_stall));
    if (e_done) m_busy = 1'b0;
    if (e_issue) begin
      m_busy     = 1'b1;
      m_rd       = rd_ex;
      m_done_cyc = cyc + ((funct7_ex == F7_FSQRT) ? SQRT_LAT : DIV_LAT);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic at_chk();
    @(negedge clk);
    #2;
  endtask

  task automatic clr_ex();
    valid_ex = 1'b0; opcode_ex = OP_INT; funct7_ex = 7'd0; rd_ex = 5'd0;
    RegWr_ex = 1'b0; MemRd_ex = 1'b0; flush_ex = 1'b0;
  endtask

  task automatic clr_id();
    opcode_id = OP_INT; funct7_id = 7'd0; rs1_id = 5'd0; rs2_id = 5'd0; rd_id = 5'd0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; fp_wr_id = 1'b0;
  endtask

  task automatic set_ex(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rd,
                        input logic rw, input logic mr);
    valid_ex = 1'b1; opcode_ex = op; funct7_ex = f7; rd_ex = rd; RegWr_ex = rw; MemRd_ex = mr;
  endtask

  task automatic set_id(input logic [6:0] op, input logic [6:0] f7, input logic [4:0] rd,
                        input logic [4:0] s1, input logic u1, input logic [4:0] s2, input logic u2);
    opcode_id = op; funct7_id = f7; rd_id = rd; fp_wr_id = 1'b1;
    rs1_id = s1; use_rs1_id = u1; rs2_id = s2; use_rs2_id = u2;
  endtask

  initial begin
    clr_ex();
    clr_id();
    rst_n = 1'b0;
    next();
    at_chk();
    chk("rst_busy",  32'(mc_busy), 32'd0);
    chk("rst_done",  32'(mc_done), 32'd0);
    chk("rst_rd",    32'(mc_rd),   32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    next();
    rst_n = 1'b1;
    next();

    // FDIV f3, dependent FADD f4,f3,f1 in ID
    set_ex(OP_FP, F7_FDIV, 5'd3, 1'b1, 1'b0);
    set_id(OP_FP, F7_FADD, 5'd4, 5'd3, 1'b1, 5'd1, 1'b1);
    for (int k = 0; k <= 17; k++) begin
      at_chk();
      chk("raw_stall",  32'(stall_o),  32'(k <= 16));
      chk("raw_bubble", 32'(bubble_o), 32'(k <= 16));
      chk("raw_done",   32'(mc_done),  32'(k == 16));
      if (k == 16) chk("raw_rd", 32'(mc_rd), 32'd3);
      next();
      if (k == 0) clr_ex();
    end

    // FDIV f5, independent FADD f6,f1,f2
    set_ex(OP_FP, F7_FDIV, 5'd5, 1'b1, 1'b0);
    set_id(OP_FP, F7_FADD, 5'd6, 5'd1, 1'b1, 5'd2, 1'b1);
    for (int k = 0; k <= 17; k++) begin
      at_chk();
      chk("ind_stall", 32'(stall_o), 32'(k == 16));
      chk("ind_done",  32'(mc_done), 32'(k == 16));
      next();
      if (k == 0) clr_ex();
    end

    // FDIV f5, FSQRT f7 waiting in ID, then issuing
    set_ex(OP_FP, F7_FDIV, 5'd5, 1'b1, 1'b0);
    set_id(OP_FP, F7_FSQRT, 5'd7, 5'd1, 1'b1, 5'd0, 1'b0);
    for (int k = 0; k <= 38; k++) begin
      at_chk();
      if (k <= 17) chk("str_stall", 32'(stall_o), 32'(k <= 16));
      if (k >= 18) begin
        chk("sqrt_done", 32'(mc_done), 32'(k == 38));
        chk("sqrt_busy", 32'(mc_busy), 32'(k >= 19));
      end
      if (k == 38) chk("sqrt_rd", 32'(mc_rd), 32'd7);
      next();
      if (k == 0) clr_ex();
      if (k == 17) begin
        set_ex(OP_FP, F7_FSQRT, 5'd7, 1'b1, 1'b0);
        clr_id();
      end
      if (k == 18) clr_ex();
    end
    next();

    // FLW f2 load-use, then the same with a flush
    set_ex(OP_FLW, 7'd0, 5'd2, 1'b1, 1'b1);
    set_id(OP_FP, F7_FMUL, 5'd8, 5'd2, 1'b1, 5'd2, 1'b1);
    at_chk();
    chk("lu_stall",  32'(stall_o),  32'd1);
    chk("lu_bubble", 32'(bubble_o), 32'd1);
    next();
    clr_ex();
    at_chk();
    chk("lu_release", 32'(stall_o), 32'd0);
    next();
    set_ex(OP_FLW, 7'd0, 5'd2, 1'b1, 1'b1);
    flush_ex = 1'b1;
    at_chk();
    chk("lu_flush_stall",  32'(stall_o),  32'd0);
    chk("lu_flush_bubble", 32'(bubble_o), 32'd0);
    next();
    clr_ex();

    // WAW on f0
    set_ex(OP_FP, F7_FDIV, 5'd0, 1'b1, 1'b0);
    set_id(OP_FP, F7_FADD, 5'd0, 5'd1, 1'b1, 5'd1, 1'b1);
    for (int k = 0; k <= 3; k++) begin
      at_chk();
      chk("waw_f0", 32'(stall_o), 32'd1);
      next();
      if (k == 0) clr_ex();
    end
    rst_n = 1'b0;
    next();
    rst_n = 1'b1;
    clr_id();
    next();

    // reset mid-FDIV when the countdown reads 7
    set_ex(OP_FP, F7_FDIV, 5'd9, 1'b1, 1'b0);
    set_id(OP_FP, F7_FADD, 5'd10, 5'd9, 1'b1, 5'd0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      at_chk();
      chk("pre_rst_stall", 32'(stall_o), 32'd1);
      next();
      if (k == 0) clr_ex();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(mc_busy), 32'd0);
    chk("mid_rst_done",  32'(mc_done), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      at_chk();
      chk("post_rst_done", 32'(mc_done), 32'd0);
      chk("post_rst_busy", 32'(mc_busy), 32'd0);
      next();
    end

    // random traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      valid_ex  = ($urandom_range(0, 3) != 0);
      rd_ex     = 5'($urandom_range(0, 3));
      RegWr_ex  = ($urandom_range(0, 4) != 0);
      MemRd_ex  = ($urandom_range(0, 4) != 0);
      flush_ex  = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0:       begin opcode_ex = OP_FP;  funct7_ex = F7_FDIV;  end
        1:       begin opcode_ex = OP_FP;  funct7_ex = F7_FSQRT; end
        2, 3:    begin opcode_ex = OP_FLW; funct7_ex = 7'($urandom_range(0, 127)); end
        4:       begin opcode_ex = OP_FP;  funct7_ex = F7_FADD;  end
        default: begin opcode_ex = OP_INT; funct7_ex = F7_FSQRT; end
      endcase
      case ($urandom_range(0, 4))
        0:       begin opcode_id = OP_FP;  funct7_id = F7_FDIV;  end
        1:       begin opcode_id = OP_INT; funct7_id = F7_FDIV;  end
        2:       begin opcode_id = OP_FP;  funct7_id = F7_FSQRT; end
        default: begin opcode_id = OP_FP;  funct7_id = F7_FMUL;  end
      endcase
      rs1_id     = 5'($urandom_range(0, 3));
      rs2_id     = 5'($urandom_range(0, 3));
      rd_id      = 5'($urandom_range(0, 3));
      use_rs1_id = 1'($urandom_range(0, 1));
      use_rs2_id = 1'($urandom_range(0, 1));
      fp_wr_id   = 1'($urandom_range(0, 1));
      next();
    end

    at_chk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
